// File: rtl/uart_tx_fifo_if.sv
// Bus-side and transmitter-side signals of the UART TX byte queue.
// The master modport is the controller/transmitter side, the slave modport is the FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1;

    logic                   wr_en_i;
    logic [7:0]             wr_data_i;
    logic                   flush_i;
    logic                   full_o;
    logic                   empty_o;
    logic [LEVEL_WIDTH-1:0] level_o;
    logic                   overflow_o;
    logic                   txd_start_o;
    logic [7:0]             txd_data_o;
    logic                   txd_busy_i;

    modport master (
        output wr_en_i, wr_data_i, flush_i, txd_busy_i,
        input  full_o, empty_o, level_o, overflow_o, txd_start_o, txd_data_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, flush_i, txd_busy_i,
        output full_o, empty_o, level_o, overflow_o, txd_start_o, txd_data_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue: buffers bus writes and hands them one at a time to the
// async transmitter through a start-pulse / busy handshake.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    uart_tx_fifo_if.slave  bus
);
    localparam int AW          = $clog2(DEPTH);
    localparam int LEVEL_WIDTH = AW + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;

    state_e                 state_q;
    logic [7:0]             mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   start_q;
    logic [7:0]             data_q;
    logic                   full, empty, push, pop;

    assign full  = (count_q == LEVEL_WIDTH'(DEPTH));
    assign empty = (count_q == '0);
    // Fullness is judged on the registered count, so a same-cycle pop never
    // makes room for a push into a full queue.
    assign push  = bus.wr_en_i && !full && !bus.flush_i;
    assign pop   = (state_q == IDLE) && !empty && !bus.txd_busy_i && !bus.flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (bus.wr_en_i && full) ovf_d = 1'b1;
            count_d = count_q + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data_i;
    end

    // Flush leaves this FSM alone so a byte already handed over still completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    data_q  <= mem_q[rd_ptr_q];
                    start_q <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: state_q <= WAIT_DONE;
                WAIT_DONE: if (!bus.txd_busy_i) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.level_o     = count_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.txd_start_o = start_q;
    assign bus.txd_data_o  = data_q;
endmodule
